// File: rtl/ibex_icache_ecc_sram_model.sv
// Single-port SRAM model for the icache data/tag path with a
// programmable read-data error-injection engine for ECC testing.
module ibex_icache_ecc_sram_model #(
    parameter int AddrW   = 8,
    parameter int DataW   = 128,
    parameter int BitIdxW = $clog2(DataW)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    input  logic               write_i,
    input  logic [AddrW-1:0]   addr_i,
    input  logic [DataW-1:0]   wdata_i,
    input  logic [DataW-1:0]   wmask_i,
    output logic [DataW-1:0]   rdata_o,
    output logic               rvalid_o,
    input  logic               inj_arm_i,
    input  logic               inj_double_i,
    input  logic [BitIdxW-1:0] inj_bit_a_i,
    input  logic [BitIdxW-1:0] inj_bit_b_i,
    input  logic [7:0]         inj_num_i,
    output logic               inj_busy_o,
    output logic               inj_done_o,
    output logic [15:0]        rd_count_o,
    output logic [15:0]        wr_count_o,
    output logic [7:0]         err_count_o
);

    localparam int Depth = 2 ** AddrW;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DONE
    } inj_state_e;

    logic [DataW-1:0] mem [Depth];

    inj_state_e       state_q, state_d;
    logic [BitIdxW-1:0] bit_a_q, bit_a_d;
    logic [BitIdxW-1:0] bit_b_q, bit_b_d;
    logic             dbl_q, dbl_d;
    logic [7:0]       rem_q, rem_d;
    logic [DataW-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [15:0]      rd_cnt_q, rd_cnt_d;
    logic [15:0]      wr_cnt_q, wr_cnt_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic             rd_req;
    logic             wr_req;
    logic             corrupt;
    logic [DataW-1:0] flip_mask;

    assign rd_req = req_i & ~write_i;
    assign wr_req = req_i & write_i;

    always_comb begin
        state_d   = state_q;
        bit_a_d   = bit_a_q;
        bit_b_d   = bit_b_q;
        dbl_d     = dbl_q;
        rem_d     = rem_q;
        corrupt   = 1'b0;
        flip_mask = '0;
        unique case (state_q)
            IDLE: begin
                // A zero-count arm is dropped so no empty DONE pulse appears
                if (inj_arm_i && inj_num_i != 8'd0) begin
                    state_d = ARMED;
                    bit_a_d = inj_bit_a_i;
                    bit_b_d = inj_bit_b_i;
                    dbl_d   = inj_double_i;
                    rem_d   = inj_num_i;
                end
            end
            ARMED: begin
                if (rd_req) begin
                    corrupt   = 1'b1;
                    flip_mask = (DataW'(1) << bit_a_q)
                              | (dbl_q ? (DataW'(1) << bit_b_q) : '0);
                    rem_d     = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rvalid_d  = rd_req;
        rdata_d   = rd_req ? (mem[addr_i] ^ flip_mask) : rdata_q;
        busy_d    = (state_d == ARMED);
        done_d    = (state_d == DONE);
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;
        if (rd_req && rd_cnt_q != 16'hFFFF) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (wr_req && wr_cnt_q != 16'hFFFF) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
        if (corrupt && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            bit_a_q   <= '0;
            bit_b_q   <= '0;
            dbl_q     <= 1'b0;
            rem_q     <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_a_q   <= bit_a_d;
            bit_b_q   <= bit_b_d;
            dbl_q     <= dbl_d;
            rem_q     <= rem_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage is never reset and never sees the injected flips
    always_ff @(posedge clk_i) begin
        if (wr_req && !rst_i) begin
            mem[addr_i] <= (mem[addr_i] & ~wmask_i) | (wdata_i & wmask_i);
        end
    end

    assign rdata_o     = rdata_q;
    assign rvalid_o    = rvalid_q;
    assign inj_busy_o  = busy_q;
    assign inj_done_o  = done_q;
    assign rd_count_o  = rd_cnt_q;
    assign wr_count_o  = wr_cnt_q;
    assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_ibex_icache_ecc_sram_model.sv
// Scoreboard bench for ibex_icache_ecc_sram_model: directed reads,
// masked writes and error-injection scenarios.
module tb_ibex_icache_ecc_sram_model;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_i;
    logic         write_i;
    logic [7:0]   addr_i;
    logic [127:0] wdata_i;
    logic [127:0] wmask_i;
    logic [127:0] rdata_o;
    logic         rvalid_o;
    logic         inj_arm_i;
    logic         inj_double_i;
    logic [6:0]   inj_bit_a_i;
    logic [6:0]   inj_bit_b_i;
    logic [7:0]   inj_num_i;
    logic         inj_busy_o;
    logic         inj_done_o;
    logic [15:0]  rd_count_o;
    logic [15:0]  wr_count_o;
    logic [7:0]   err_count_o;

    ibex_icache_ecc_sram_model dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .write_i      (write_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .wmask_i      (wmask_i),
        .rdata_o      (rdata_o),
        .rvalid_o     (rvalid_o),
        .inj_arm_i    (inj_arm_i),
        .inj_double_i (inj_double_i),
        .inj_bit_a_i  (inj_bit_a_i),
        .inj_bit_b_i  (inj_bit_b_i),
        .inj_num_i    (inj_num_i),
        .inj_busy_o   (inj_busy_o),
        .inj_done_o   (inj_done_o),
        .rd_count_o   (rd_count_o),
        .wr_count_o   (wr_count_o),
        .err_count_o  (err_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [127:0] data;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   done_cnt = 0;

    localparam logic [127:0] ONES = '1;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Response monitor: every rvalid must match the oldest expectation
    always @(negedge clk_i) begin
        exp_t e;
        if (rvalid_o === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_rvalid: rdata %h at cycle %0d",
                         rdata_o, cyc);
            end else begin
                e = sb.pop_front();
                if (rdata_o !== e.data || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL rdata: got %h @%0d want %h @%0d",
                             rdata_o, cyc, e.data, e.cyc);
                end
            end
        end
        if (inj_done_o === 1'b1) done_cnt++;
    end

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        req_i = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [127:0] d,
                      input logic [127:0] m);
        req_i   = 1'b1;
        write_i = 1'b1;
        addr_i  = a;
        wdata_i = d;
        wmask_i = m;
        tick();
        req_i   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [127:0] exp);
        exp_t e;
        e.data  = exp;
        e.cyc   = cyc + 1;
        sb.push_back(e);
        req_i   = 1'b1;
        write_i = 1'b0;
        addr_i  = a;
        tick();
        req_i   = 1'b0;
    endtask

    task automatic arm(input logic [6:0] a, input logic [6:0] b,
                       input logic dbl, input logic [7:0] num);
        inj_arm_i    = 1'b1;
        inj_bit_a_i  = a;
        inj_bit_b_i  = b;
        inj_double_i = dbl;
        inj_num_i    = num;
        tick();
        inj_arm_i    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i        = 1'b1;
        req_i        = 1'b0;
        write_i      = 1'b0;
        addr_i       = '0;
        wdata_i      = '0;
        wmask_i      = '0;
        inj_arm_i    = 1'b0;
        inj_double_i = 1'b0;
        inj_bit_a_i  = '0;
        inj_bit_b_i  = '0;
        inj_num_i    = '0;
        idle(3);
        chk("rst_rdata", rdata_o, '0);
        chk("rst_rvalid", {127'd0, rvalid_o}, '0);
        chk("rst_busy", {127'd0, inj_busy_o}, '0);
        chk("rst_done", {127'd0, inj_done_o}, '0);
        chk("rst_cnts", {rd_count_o, wr_count_o, err_count_o}, '0);
        rst_i = 1'b0;
        idle(1);

        wr(8'h10, ONES, ONES);
        wr(8'h10, '0, 128'hFFFF);
        rd(8'h10, ~128'hFFFF);
        idle(1);
        wr(8'h03, 128'hA5, ONES);
        rd(8'h03, 128'hA5);
        wr(8'h20, '0, ONES);
        idle(1);
        chk("wr_count_4", {112'd0, wr_count_o}, 128'd4);
        chk("rd_count_2", {112'd0, rd_count_o}, 128'd2);

        arm(7'd5, 7'd0, 1'b0, 8'd2);
        chk("single_busy", {127'd0, inj_busy_o}, 128'd1);
        rd(8'h20, 128'h20);
        rd(8'h20, 128'h20);
        chk("single_done_pulse", {127'd0, inj_done_o}, 128'd1);
        chk("single_busy_off", {127'd0, inj_busy_o}, '0);
        rd(8'h20, '0);
        chk("single_done_one_cycle", {127'd0, inj_done_o}, '0);
        rd(8'h20, '0);
        idle(1);
        chk("single_err", {120'd0, err_count_o}, 128'd2);
        chk("single_done_cnt", 128'(done_cnt), 128'd1);
        chk("rd_count_6", {112'd0, rd_count_o}, 128'd6);

        arm(7'd0, 7'd127, 1'b1, 8'd1);
        rd(8'h20, {1'b1, 126'd0, 1'b1});
        rd(8'h20, '0);
        arm(7'd7, 7'd7, 1'b1, 8'd1);
        rd(8'h20, 128'h80);
        idle(2);
        chk("double_err", {120'd0, err_count_o}, 128'd4);
        chk("double_done_cnt", 128'(done_cnt), 128'd3);

        arm(7'd9, 7'd0, 1'b0, 8'd0);
        chk("num0_busy", {127'd0, inj_busy_o}, '0);
        idle(2);
        chk("num0_no_done", 128'(done_cnt), 128'd3);

        inj_arm_i    = 1'b1;
        inj_bit_a_i  = 7'd1;
        inj_double_i = 1'b0;
        inj_num_i    = 8'd1;
        rd(8'h20, '0);
        inj_arm_i    = 1'b0;
        chk("armrd_busy", {127'd0, inj_busy_o}, 128'd1);
        rd(8'h20, 128'h2);
        idle(2);
        chk("armrd_done_cnt", 128'(done_cnt), 128'd4);

        arm(7'd2, 7'd0, 1'b0, 8'd2);
        arm(7'd9, 7'd9, 1'b1, 8'd5);
        rd(8'h20, 128'h4);
        rd(8'h20, 128'h4);
        rd(8'h20, '0);
        idle(1);
        chk("rearm_busy", {127'd0, inj_busy_o}, '0);
        chk("rearm_done_cnt", 128'(done_cnt), 128'd5);
        chk("rearm_err", {120'd0, err_count_o}, 128'd7);

        arm(7'd3, 7'd0, 1'b0, 8'd3);
        rd(8'h20, 128'h8);
        rst_i = 1'b1;
        tick();
        chk("mid_rst_busy", {127'd0, inj_busy_o}, '0);
        chk("mid_rst_rvalid", {127'd0, rvalid_o}, '0);
        chk("mid_rst_cnts", {rd_count_o, wr_count_o, err_count_o}, '0);
        rst_i = 1'b0;
        idle(2);
        chk("mid_rst_no_done", 128'(done_cnt), 128'd5);
        rd(8'h10, ~128'hFFFF);
        rd(8'h03, 128'hA5);
        idle(1);
        chk("post_rst_rd", {112'd0, rd_count_o}, 128'd2);

        for (int r = 0; r < 2; r++) begin
            arm(7'd4, 7'd0, 1'b0, 8'd200);
            for (int i = 0; i < 200; i++) rd(8'h20, 128'h10);
            idle(2);
        end
        chk("err_saturate", {120'd0, err_count_o}, 128'd255);
        chk("sat_done_cnt", 128'(done_cnt), 128'd7);
        chk("sat_rd_count", {112'd0, rd_count_o}, 128'd402);
        chk("sat_wr_count", {112'd0, wr_count_o}, '0);

        idle(3);
        chk("sb_drained", 128'(sb.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
